// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared FSM encodings, bus widths and the 8N1 frame builder for the SRAM-to-UART transmit path.
// Pure declarations: no latency, no backpressure.
package uart_sram_tx_interface_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    localparam logic [2:0] S_TX_IDLE = 3'd0;
    localparam logic [2:0] S_TX_READ = 3'd1;
    localparam logic [2:0] S_TX_WAIT = 3'd2;
    localparam logic [2:0] S_TX_HI   = 3'd3;
    localparam logic [2:0] S_TX_LO   = 3'd4;
    localparam logic [2:0] S_TX_DONE = 3'd5;

    // Bit 0 goes on the line first: start bit, data LSB first, then the stop bit.
    function automatic logic [9:0] uart_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// One 8N1 frame per Load; the line leaves idle on the cycle after Load, each bit lasts CLKS_PER_BIT clocks.
// Ready is high when idle and on the last stop-bit cycle, so back-to-back Loads chain with no idle gap.
module uart_byte_tx
    import uart_sram_tx_interface_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Load,
    input  logic [7:0] Byte,
    output logic       Ready,
    output logic       Tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

    logic [9:0]    shift_q, shift_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic          active_q, active_d;
    logic          bit_end;

    assign bit_end = (baud_q == LAST_TICK);
    assign Ready   = !active_q || (bit_end && (bit_q == 4'd9));
    assign Tx      = active_q ? shift_q[0] : 1'b1;

    always_comb begin
        shift_d  = shift_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        active_d = active_q;
        if (Load) begin
            shift_d  = uart_frame(Byte);
            baud_d   = '0;
            bit_d    = 4'd0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (bit_end) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            shift_q  <= '1;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Streams Word_count SRAM words out as 8N1 frames, high byte first; first start bit at Start+SRAM_READ_LAT+2.
// No backpressure: Start is only honoured in S_TX_IDLE, and the next word is prefetched during each low-byte frame.
module uart_sram_tx_interface
    import uart_sram_tx_interface_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 434,
    parameter int SRAM_READ_LAT = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_address,
    input  logic [ADDR_W-1:0] Word_count,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic              SRAM_we_n,
    output logic [DATA_W-1:0] SRAM_write_data,
    input  logic [DATA_W-1:0] SRAM_read_data,
    output logic              UART_TX_O
);

    // S_TX_WAIT lasts SRAM_READ_LAT-1 cycles; SRAM_READ_LAT must be at least 2.
    localparam logic [3:0] WAIT_LAST = 4'(SRAM_READ_LAT - 2);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [7:0]        hold_q, hold_d;
    logic [3:0]        wait_q, wait_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              byte_load;
    logic [7:0]        byte_dat;
    logic              byte_rdy;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        hold_d    = hold_q;
        wait_d    = wait_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        byte_load = 1'b0;
        byte_dat  = hold_q;
        case (state_q)
            S_TX_IDLE: begin
                if (Start) begin
                    if (Word_count != '0) begin
                        addr_d   = Start_address;
                        remain_d = Word_count;
                        busy_d   = 1'b1;
                        state_d  = S_TX_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_TX_READ: begin
                wait_d  = 4'd0;
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_TX_HI;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_TX_HI: begin
                // High byte goes straight from the SRAM bus; only the low byte needs holding.
                if (byte_rdy) begin
                    byte_load = 1'b1;
                    byte_dat  = SRAM_read_data[15:8];
                    hold_d    = SRAM_read_data[7:0];
                    remain_d  = remain_q - 1'b1;
                    state_d   = S_TX_LO;
                end
            end
            S_TX_LO: begin
                if (byte_rdy) begin
                    byte_load = 1'b1;
                    if (remain_q != '0) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_TX_HI;
                    end else begin
                        state_d = S_TX_DONE;
                    end
                end
            end
            S_TX_DONE: begin
                if (byte_rdy) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_TX_IDLE;
                end
            end
            default: state_d = S_TX_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= S_TX_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            hold_q   <= 8'd0;
            wait_q   <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            hold_q   <= hold_d;
            wait_q   <= wait_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .Clock (Clock),
        .Resetn(Resetn),
        .Load  (byte_load),
        .Byte  (byte_dat),
        .Ready (byte_rdy),
        .Tx    (UART_TX_O)
    );

    assign Busy            = busy_q;
    assign Done            = done_q;
    assign SRAM_address    = addr_q;
    assign SRAM_we_n       = 1'b1;
    assign SRAM_write_data = '0;

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Bench for uart_sram_tx_interface: a line-level UART decoder and a Done monitor pop expectations
// that the stimulus side pushes from a memory-image reference model.
module tb_uart_sram_tx_interface;

    localparam int C   = 16;
    localparam int LAT = 2;

    typedef struct {
        logic [7:0] b;
        int         t;
    } frame_t;

    logic        clk;
    logic        Resetn;
    logic        Start;
    logic [17:0] Start_address;
    logic [17:0] Word_count;
    logic        Busy;
    logic        Done;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_write_data;
    logic [15:0] SRAM_read_data;
    logic        UART_TX_O;

    uart_sram_tx_interface #(
        .CLKS_PER_BIT (C),
        .SRAM_READ_LAT(LAT)
    ) dut (
        .Clock          (clk),
        .Resetn         (Resetn),
        .Start          (Start),
        .Start_address  (Start_address),
        .Word_count     (Word_count),
        .Busy           (Busy),
        .Done           (Done),
        .SRAM_address   (SRAM_address),
        .SRAM_we_n      (SRAM_we_n),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_read_data (SRAM_read_data),
        .UART_TX_O      (UART_TX_O)
    );

    logic [15:0] mem [0:262143];
    logic [17:0] a1;
    logic [15:0] rd;
    int          cyc;
    int          n_cmp;
    int          n_fail;
    frame_t      exp_q[$];
    int          done_q[$];
    logic [17:0] alog[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM with two clocks from address to data.
    always_ff @(posedge clk) begin
        cyc <= cyc + 1;
        a1  <= SRAM_address;
        rd  <= mem[a1];
    end
    assign SRAM_read_data = rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line decoder: samples each bit mid-period and scores whole frames.
    bit         in_frame;
    int         fstart;
    logic [9:0] fbits;
    initial begin
        in_frame = 0;
        forever begin
            @(negedge clk);
            if (!Resetn) begin
                in_frame = 0;
            end else begin
                if (!in_frame && UART_TX_O == 1'b0) begin
                    in_frame = 1;
                    fstart   = cyc;
                end
                if (in_frame && ((cyc - fstart) % C) == C / 2) begin
                    fbits[(cyc - fstart) / C] = UART_TX_O;
                    if ((cyc - fstart) / C == 9) begin
                        frame_t e;
                        in_frame = 0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", {24'd0, fbits[8:1]}, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_byte", {24'd0, fbits[8:1]}, {24'd0, e.b});
                            check("frame_start_cycle", fstart, e.t);
                            check("frame_start_stop_bits", {30'd0, fbits[9], fbits[0]}, 32'd2);
                        end
                    end
                end
                if (Done) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", cyc, 32'hFFFF_FFFF);
                    end else begin
                        check("done_cycle", cyc, done_q.pop_front());
                        check("busy_low_at_done", {31'd0, Busy}, 32'd0);
                    end
                end
                if (Busy && (alog.size() == 0 || alog[$] != SRAM_address)) begin
                    alog.push_back(SRAM_address);
                end
            end
        end
    end

    // Reference model: word w of a transfer comes from mem[(a+w) mod 2^18]; frames back-to-back.
    task automatic issue(input logic [17:0] a, input logic [17:0] n, output int t0);
        logic [15:0] d;
        int          first;
        Start_address = a;
        Word_count    = n;
        Start         = 1'b1;
        t0            = cyc;
        first         = t0 + LAT + 2;
        alog.delete();
        for (int w = 0; w < int'(n); w++) begin
            d = mem[18'(a + w)];
            exp_q.push_back('{b: d[15:8], t: first + (2 * w) * 10 * C});
            exp_q.push_back('{b: d[7:0], t: first + (2 * w + 1) * 10 * C});
        end
        done_q.push_back((n == 0) ? t0 + 1 : first + int'(n) * 20 * C);
        tick();
        Start         = 1'b0;
        Start_address = 18'($urandom);
        Word_count    = 18'($urandom_range(1, 9));
    endtask

    task automatic run_xfer(input logic [17:0] a, input logic [17:0] n, input bit stray);
        int t0;
        issue(a, n, t0);
        if (stray) begin
            repeat ($urandom_range(2, 10 * C)) tick();
            Start_address = 18'($urandom);
            Word_count    = 18'd7;
            Start         = 1'b1;
            tick();
            Start = 1'b0;
        end
        for (int k = 0; k < int'(n) * 20 * C + 40; k++) begin
            if (exp_q.size() == 0 && done_q.size() == 0) break;
            tick();
        end
        check("xfer_drained", exp_q.size() + done_q.size(), 0);
        exp_q.delete();
        done_q.delete();
        check("addr_count", alog.size(), {14'd0, n});
        for (int i = 0; i < alog.size() && i < int'(n); i++) begin
            check("addr_seq", {14'd0, alog[i]}, {14'd0, 18'(a + i)});
        end
        repeat (3) tick();
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        logic [17:0] pre;
        logic [17:0] ra;
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);
        mem[0]       = 16'hA55A;
        mem[100]     = 16'h1111;
        mem[101]     = 16'h2222;
        mem[102]     = 16'h3333;
        Resetn        = 1'b0;
        Start         = 1'b0;
        Start_address = '0;
        Word_count    = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_tx", {31'd0, UART_TX_O}, 1);
        check("rst_busy", {31'd0, Busy}, 0);
        check("rst_done", {31'd0, Done}, 0);
        check("rst_addr", {14'd0, SRAM_address}, 0);
        check("rst_we_n", {31'd0, SRAM_we_n}, 1);
        check("rst_wdata", {16'd0, SRAM_write_data}, 0);
        tick();
        Resetn = 1'b1;
        repeat (2) tick();

        run_xfer(18'd0, 18'd1, 1'b0);
        run_xfer(18'd100, 18'd3, 1'b0);

        pre = SRAM_address;
        run_xfer(18'h00155, 18'd0, 1'b0);
        check("count0_addr_unchanged", {14'd0, SRAM_address}, {14'd0, pre});

        run_xfer(18'h3FFFF, 18'd2, 1'b0);
        run_xfer(18'h00200, 18'd2, 1'b1);

        // Reset during data bit 3 of the first frame.
        issue(18'h00300, 18'd2, t0);
        while (cyc < t0 + LAT + 2 + 4 * C + C / 2) tick();
        Resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx", {31'd0, UART_TX_O}, 1);
        check("midrst_busy", {31'd0, Busy}, 0);
        check("midrst_done", {31'd0, Done}, 0);
        exp_q.delete();
        done_q.delete();
        tick();
        Resetn = 1'b1;
        repeat (2) tick();
        run_xfer(18'h00300, 18'd2, 1'b0);

        for (int r = 0; r < 4; r++) begin
            ra = ($urandom_range(0, 1) == 1) ? 18'h3FFFE : 18'($urandom);
            run_xfer(ra, 18'($urandom_range(1, 2)), bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
